// File: rtl/difficulty_select_ctrl_pkg.sv
// Shared types and constants for the difficulty selection controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package difficulty_select_ctrl_pkg;

    typedef enum logic [1:0] {
        SELECT = 2'd0,
        HOLD   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    typedef logic [1:0] diff_t;

    localparam diff_t DIFF_NONE = 2'd0;
    localparam diff_t DIFF_EASY = 2'd1;
    localparam diff_t DIFF_MED  = 2'd2;
    localparam diff_t DIFF_HARD = 2'd3;

    // Bit positions inside btn_level and the internal button vectors
    localparam int BTN_L = 0;
    localparam int BTN_C = 1;
    localparam int BTN_R = 2;
    localparam int BTN_D = 3;
    localparam int BTN_U = 4;

`ifdef DIFF_CYCLE_EN
    localparam int NUM_BTN = 5;

    function automatic diff_t diff_cycle(input diff_t cur);
        diff_t nxt;
        case (cur)
            DIFF_EASY: nxt = DIFF_MED;
            DIFF_MED:  nxt = DIFF_HARD;
            default:   nxt = DIFF_EASY;
        endcase
        return nxt;
    endfunction
`else
    localparam int NUM_BTN = 4;
`endif

endpackage

// File: rtl/difficulty_select_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, debounce counter, stable level, press pulse.
// Latency: raw edge to level/press = 2 + DEBOUNCE_CYCLES cycles.
// Backpressure: none; press is a one-cycle pulse that is never held.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
            press  <= 1'b0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
            press  <= 1'b0;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Only a rising stable transition reports a press
                cnt   <= '0;
                level <= ~level;
                press <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/difficulty_select_ctrl.sv
// Latched difficulty selection with pending/ack handshake; optional btn_u cycling via DIFF_CYCLE_EN.
// Latency: button press pulse to difficulty_out/pending = 1 cycle (raw edge to output = 3 + DEBOUNCE_CYCLES).
// Backpressure: selection held pending until ack; then locked until btn_d or game_over.
module difficulty_select_ctrl
    import difficulty_select_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DATA_W          = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               btn_l,
    input  logic               btn_c,
    input  logic               btn_r,
    input  logic               btn_d,
`ifdef DIFF_CYCLE_EN
    input  logic               btn_u,
`endif
    input  logic               ack,
    input  logic               game_over,
    output logic [DATA_W-1:0]  difficulty_out,
    output logic               pending,
    output logic               locked,
    output logic [NUM_BTN-1:0] btn_level
);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_press;

    assign btn_raw[BTN_L] = btn_l;
    assign btn_raw[BTN_C] = btn_c;
    assign btn_raw[BTN_R] = btn_r;
    assign btn_raw[BTN_D] = btn_d;
`ifdef DIFF_CYCLE_EN
    assign btn_raw[BTN_U] = btn_u;
`endif

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clock   (clock),
            .reset   (reset),
            .btn_raw (btn_raw[i]),
            .level   (btn_level[i]),
            .press   (btn_press[i])
        );
    end

    // Direct selection from L/C/R with fixed priority L > C > R
    logic  sel_vld;
    diff_t sel_val;

    always_comb begin
        sel_vld = 1'b1;
        sel_val = DIFF_NONE;
        if (btn_press[BTN_L]) begin
            sel_val = DIFF_EASY;
        end else if (btn_press[BTN_C]) begin
            sel_val = DIFF_MED;
        end else if (btn_press[BTN_R]) begin
            sel_val = DIFF_HARD;
        end else begin
            sel_vld = 1'b0;
        end
    end

    state_t state_q;
    state_t state_nxt;
    diff_t  diff_q;
    diff_t  diff_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= SELECT;
            diff_q  <= DIFF_NONE;
        end else begin
            state_q <= state_nxt;
            diff_q  <= diff_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        diff_nxt  = diff_q;
        case (state_q)
            SELECT: begin
                if (sel_vld) begin
                    state_nxt = HOLD;
                    diff_nxt  = sel_val;
`ifdef DIFF_CYCLE_EN
                end else if (btn_press[BTN_U]) begin
                    state_nxt = HOLD;
                    diff_nxt  = DIFF_EASY;
`endif
                end
            end
            HOLD: begin
                // Cancel beats ack, and ack locks the value held before any same-cycle press
                if (btn_press[BTN_D]) begin
                    state_nxt = SELECT;
                    diff_nxt  = DIFF_NONE;
                end else if (ack) begin
                    state_nxt = LOCKED;
                end else if (sel_vld) begin
                    diff_nxt = sel_val;
`ifdef DIFF_CYCLE_EN
                end else if (btn_press[BTN_U]) begin
                    diff_nxt = diff_cycle(diff_q);
`endif
                end
            end
            LOCKED: begin
                if (btn_press[BTN_D] || game_over) begin
                    state_nxt = SELECT;
                    diff_nxt  = DIFF_NONE;
                end
            end
            default: begin
                state_nxt = SELECT;
                diff_nxt  = DIFF_NONE;
            end
        endcase
    end

    assign difficulty_out = DATA_W'(diff_q);
    assign pending        = (state_q == HOLD);
    assign locked         = (state_q == LOCKED);

endmodule

// File: tb/tb_difficulty_select_ctrl.sv
// Self-checking bench for difficulty_select_ctrl (default build, DEBOUNCE_CYCLES=4).
module tb_difficulty_select_ctrl;

    localparam int DB = 4;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    btn = 4'b0;
    logic          ack = 1'b0;
    logic          game_over = 1'b0;
    logic [DW-1:0] difficulty_out;
    logic          pending;
    logic          locked;
    logic [3:0]    btn_level;

    always #5 clock = ~clock;

    difficulty_select_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .DATA_W(DW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .btn_l          (btn[0]),
        .btn_c          (btn[1]),
        .btn_r          (btn[2]),
        .btn_d          (btn[3]),
        .ack            (ack),
        .game_over      (game_over),
        .difficulty_out (difficulty_out),
        .pending        (pending),
        .locked         (locked),
        .btn_level      (btn_level)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: raw samples per button, stable level flips once the last
    // DB synchronized samples all disagree with it; selection rules as flags.
    logic [15:0] hist [4];
    logic [3:0]  m_stable;
    logic [3:0]  m_press;
    logic [1:0]  m_diff;
    logic        m_pend;
    logic        m_lock;
    bit          model_ok = 1'b0;

    function automatic logic [1:0] pick(input logic [3:0] p);
        if (p[0]) return 2'd1;
        if (p[1]) return 2'd2;
        return 2'd3;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            for (int b = 0; b < 4; b++) hist[b] = '0;
            m_stable = '0;
            m_press  = '0;
            m_diff   = '0;
            m_pend   = 1'b0;
            m_lock   = 1'b0;
            model_ok = 1'b1;
        end else begin
            if (m_lock) begin
                if (m_press[3] || game_over) begin
                    m_lock = 1'b0;
                    m_diff = 2'd0;
                end
            end else if (m_pend) begin
                if (m_press[3]) begin
                    m_pend = 1'b0;
                    m_diff = 2'd0;
                end else if (ack) begin
                    m_pend = 1'b0;
                    m_lock = 1'b1;
                end else if (|m_press[2:0]) begin
                    m_diff = pick(m_press);
                end
            end else if (|m_press[2:0]) begin
                m_diff = pick(m_press);
                m_pend = 1'b1;
            end
            for (int b = 0; b < 4; b++) begin
                bit all_diff;
                all_diff = 1'b1;
                // hist[b][1] is the sample the second sync flop presents at this edge
                for (int j = 1; j <= DB; j++)
                    if (hist[b][j] == m_stable[b]) all_diff = 1'b0;
                m_press[b] = all_diff && !m_stable[b];
                if (all_diff) m_stable[b] = ~m_stable[b];
                hist[b] = {hist[b][14:0], btn[b]};
            end
        end
    end

    always @(negedge clock) begin
        if (model_ok) begin
            check("difficulty_out", difficulty_out, 32'(m_diff));
            check("pending", 32'(pending), 32'(m_pend));
            check("locked", 32'(locked), 32'(m_lock));
            check("btn_level", 32'(btn_level), 32'(m_stable));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic expect_out(input string tag, input int d, input bit p, input bit l);
        check({tag, "_diff"}, difficulty_out, 32'(d));
        check({tag, "_pend"}, 32'(pending), 32'(p));
        check({tag, "_lock"}, 32'(locked), 32'(l));
    endtask

    bit seen_l;

    initial begin
        // Reset held for 3 cycles
        cyc(3);
        expect_out("reset", 0, 1'b0, 1'b0);
        check("reset_level", 32'(btn_level), 32'd0);
        reset = 1'b0;
        cyc(5);
        expect_out("idle", 0, 1'b0, 1'b0);

        // Bounce on L: 2-cycle runs never qualify
        seen_l = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) btn[0] = ~btn[0];
            cyc(1);
            if (btn_level[0]) seen_l = 1'b1;
        end
        btn[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if (btn_level[0]) seen_l = 1'b1;
        end
        check("bounce_level_rose", 32'(seen_l), 32'd0);
        expect_out("bounce", 0, 1'b0, 1'b0);

        // Single press on C: level at cycle 6, pending/value at cycle 7
        btn[1] = 1'b1;
        cyc(6);
        check("press_c_level", 32'(btn_level[1]), 32'd1);
        check("press_c_early_pend", 32'(pending), 32'd0);
        cyc(1);
        expect_out("press_c", 2, 1'b1, 1'b0);
        cyc(3);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        expect_out("ack_c", 2, 1'b0, 1'b1);
        btn[1] = 1'b0;
        cyc(8);

        // game_over leaves LOCKED
        game_over = 1'b1;
        cyc(1);
        game_over = 1'b0;
        expect_out("game_over", 0, 1'b0, 1'b0);

        // L and R together -> L wins; R alone later overwrites
        btn[0] = 1'b1;
        btn[2] = 1'b1;
        cyc(7);
        expect_out("prio_lr", 1, 1'b1, 1'b0);
        btn = 4'b0;
        cyc(8);
        btn[2] = 1'b1;
        cyc(7);
        expect_out("overwrite_r", 3, 1'b1, 1'b0);
        btn[2] = 1'b0;
        cyc(8);
        btn[0] = 1'b1;
        cyc(7);
        expect_out("back_to_l", 1, 1'b1, 1'b0);
        btn[0] = 1'b0;
        cyc(8);

        // ack coincident with a C press pulse: held value 1 locks
        btn[1] = 1'b1;
        cyc(6);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        expect_out("ack_vs_press", 1, 1'b0, 1'b1);
        btn[1] = 1'b0;
        cyc(8);
        btn[1] = 1'b1;
        cyc(7);
        expect_out("locked_ignore_c", 1, 1'b0, 1'b1);
        btn[1] = 1'b0;
        cyc(8);

        // btn_d leaves LOCKED, then cancels from HOLD
        btn[3] = 1'b1;
        cyc(7);
        expect_out("d_from_locked", 0, 1'b0, 1'b0);
        btn[3] = 1'b0;
        cyc(8);
        btn[0] = 1'b1;
        cyc(7);
        expect_out("hold_again", 1, 1'b1, 1'b0);
        btn[0] = 1'b0;
        cyc(8);
        btn[3] = 1'b1;
        cyc(7);
        expect_out("d_from_hold", 0, 1'b0, 1'b0);
        btn[3] = 1'b0;
        cyc(8);

        // Reset while in HOLD
        btn[2] = 1'b1;
        cyc(7);
        expect_out("hold_r", 3, 1'b1, 1'b0);
        reset = 1'b1;
        cyc(1);
        expect_out("reset_in_hold", 0, 1'b0, 1'b0);
        check("reset_in_hold_level", 32'(btn_level), 32'd0);
        reset = 1'b0;
        btn[2] = 1'b0;
        cyc(2);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 15) == 0) btn[b] = ~btn[b];
            ack       = ($urandom_range(0, 7) == 0);
            game_over = ($urandom_range(0, 31) == 0);
            reset     = ($urandom_range(0, 499) == 0);
            cyc(1);
        end
        reset = 1'b0;
        ack = 1'b0;
        game_over = 1'b0;
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
